crazy_light_seq: RTL and testbench
==================================

Name: crazy_light_seq

Overview:
Parametrised successor to the team's six-hue RGB light sequencer. Steps through the hue wheel R, RG, G, GB, B, RB. Adds a programmable dwell time per step, four sequencing modes, a brightness level, and pause/resume. Sits between the board control inputs (buttons or registers) and the RGB LED drivers.

Parameters:
COLOR_W, 4, width of each colour channel output and of the level input
DWELL_W, 8, width of the dwell input and of the internal dwell counter

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  level-sampled start request
stop  in  1  level-sampled stop request; highest priority
pause  in  1  while high in RUN, the sequence freezes
mode  in  2  0 forward loop, 1 reverse loop, 2 bounce, 3 one-shot; latched on start
dwell  in  DWELL_W  each step lasts dwell+1 cycles; sampled at every step load
level  in  COLOR_W  drive value for lit channels
r  out  COLOR_W  red drive
g  out  COLOR_W  green drive
b  out  COLOR_W  blue drive
step_idx  out  3  current hue step, 0..5
running  out  1  high in RUN or PAUSE
cycle_done  out  1  one-cycle pulse at the end of a full pass

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE, step_idx 0, direction up, dwell counter 0, latched mode 0.
  - r, g, b, running and cycle_done all 0.
- Hue masks {r,g,b}: step 0=100, 1=110, 2=010, 3=011, 4=001, 5=101. A lit channel is driven to level; an unlit channel is 0.
- All outputs are registered and update on the same edge as the state register. A change on level is visible one edge later.
- States: IDLE, RUN, PAUSE.
- IDLE:
  - Outputs are 0.
  - stop=1: stay in IDLE. stop beats a simultaneous start.
  - start=1 and stop=0 on an edge: on that edge go to RUN, latch mode, load the counter with dwell, and set the entry step.
  - Entry step is 5 for reverse; 0 for forward, bounce and one-shot. Bounce direction starts up.
  - The colour of the entry step appears on that same edge.
- RUN:
  - stop=1: go to IDLE next edge, outputs 0, no cycle_done pulse.
  - Otherwise pause=1: go to PAUSE; the counter and step freeze.
  - Otherwise, counter non-zero: decrement it.
  - Otherwise (counter zero): advance the step per mode and reload the counter with the current dwell.
  - start is ignored while in RUN.
- PAUSE:
  - Outputs, step and counter hold.
  - stop=1: go to IDLE.
  - pause=0: return to RUN. The counter resumes from its held value, so the total step length is still dwell+1 active cycles.
- Step advance by mode:
  - Forward: 0→1→…→5→0. cycle_done pulses on the 5→0 edge.
  - Reverse: 5→4→…→0→5. cycle_done pulses on the 0→5 edge.
  - Bounce: 0,1,2,3,4,5,4,3,2,1,0,1,… Direction flips at 5 and at 0; endpoints are not repeated. cycle_done pulses on the 1→0 edge.
  - One-shot: 0..5 once. When step 5 expires: go to IDLE, outputs 0, pulse cycle_done on that edge, step_idx returns to 0.
- dwell=0 gives one cycle per step. dwell = max gives 2^DWELL_W cycles per step.
- A mode change during RUN has no effect until the next start.
- Reset asserted mid-sequence forces the reset values immediately. After release the block waits for start.
- Default branch (illegal state encoding): go to IDLE.

Decomposition:
- Shared package crazy_light_pkg holds:
  - state enum (IDLE, RUN, PAUSE)
  - mode encodings (MODE_FWD, MODE_REV, MODE_BOUNCE, MODE_ONESHOT)
  - hue mask table constant (6 × 3 bits)
  - STEP_FIRST = 0, STEP_LAST = 5
- One sub-module, dwell_timer: a DWELL_W down-counter.
  - Inputs: load, load value, enable.
  - Output: expired (counter zero).
  - Instantiated once, with the same clock and active-low asynchronous reset.

Test Plan:
- Reset and start: reset low, then high; start=1 for one cycle, mode=0, dwell=2, level=4'hF. Required: after reset r=g=b=0; then steps 0..5 each held 3 cycles (r=F,g=0,b=0 first); cycle_done pulses once at the 5→0 edge; loop continues.
- Bounce with brightness: mode=2, dwell=0, level=4'h7. Required: step_idx sequence 0,1,2,3,4,5,4,3,2,1,0,1 on consecutive cycles; lit channels read 4'h7; cycle_done only on the 1→0 edge.
- Pause: forward run, dwell=3; pause=1 for 5 cycles mid-step after 2 counted cycles. Required: outputs and step_idx frozen and running=1 throughout; on resume the step lasts 2 more cycles, then advances.
- Stop priority: start=1 and stop=1 together in IDLE → stays IDLE. stop=1 while in PAUSE → IDLE next edge, outputs 0, running=0, no cycle_done.
- One-shot and reverse: mode=3, dwell=1 → 12 active cycles, then IDLE with a cycle_done pulse on the exit edge. Then mode=1 → first colour r=F,b=F (step 5), stepping down to 0 and wrapping to 5 with cycle_done.
- Asynchronous reset mid-run: reset asserted between clock edges during step 3. Required: outputs go to 0 without waiting for a clock edge; after release, the block stays IDLE until start.

Source files
------------

// File: rtl/crazy_light_pkg.sv
// Shared types and constants for the six-hue light sequencer.
// Holds state and mode encodings, the hue mask table and the step range.
// No logic here.
package crazy_light_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_FWD     = 2'd0;
    localparam logic [1:0] MODE_REV     = 2'd1;
    localparam logic [1:0] MODE_BOUNCE  = 2'd2;
    localparam logic [1:0] MODE_ONESHOT = 2'd3;

    localparam logic [2:0] STEP_FIRST = 3'd0;
    localparam logic [2:0] STEP_LAST  = 3'd5;

    // {r,g,b} lit mask per step; index 0 is the rightmost entry.
    // Entries 6 and 7 are unreachable and kept dark so any 3-bit index is safe.
    localparam logic [7:0][2:0] HUE_MASK = {
        3'b000, 3'b000,
        3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100
    };

endpackage

// File: rtl/dwell_timer.sv
// Dwell down-counter: load wins over enable, decrement stops at zero.
// Latency: expired reflects the counter register, one edge after load/decrement.
// No backpressure; the caller gates enable.
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               enable,
    output logic               expired
);

    logic [DWELL_W-1:0] cnt;

    // Load a fresh dwell or count down towards zero while enabled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - DWELL_W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/crazy_light_seq.sv
// RGB hue-wheel sequencer with dwell, four modes, brightness and pause.
// Latency: all outputs registered; a start shows the entry colour on the same edge.
// No backpressure; stop overrides everything, pause freezes step and counter.
module crazy_light_seq
    import crazy_light_pkg::*;
#(
    parameter int COLOR_W = 4,
    parameter int DWELL_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [COLOR_W-1:0] level,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic [2:0]         step_idx,
    output logic               running,
    output logic               cycle_done
);

    state_t     state;
    logic [1:0] mode_q;
    logic       dir_up;

    logic       expired;
    logic       tmr_load;
    logic       tmr_en;

    logic [2:0] adv_step;
    logic       adv_dir_up;
    logic       adv_wrap;
    logic [2:0] entry_step;

    // Channel drive for a given step: lit channels take level, others are dark.
    function automatic logic [3*COLOR_W-1:0] hue_drive(input logic [2:0] s,
                                                       input logic [COLOR_W-1:0] lv);
        logic [2:0] m;
        m = HUE_MASK[s];
        return {{COLOR_W{m[2]}} & lv, {COLOR_W{m[1]}} & lv, {COLOR_W{m[0]}} & lv};
    endfunction

    assign entry_step = (mode == MODE_REV) ? STEP_LAST : STEP_FIRST;

    // Next step, bounce direction and end-of-pass flag for the latched mode.
    always_comb begin
        adv_step   = step_idx;
        adv_dir_up = dir_up;
        adv_wrap   = 1'b0;
        case (mode_q)
            MODE_FWD: begin
                if (step_idx == STEP_LAST) begin
                    adv_step = STEP_FIRST;
                    adv_wrap = 1'b1;
                end else begin
                    adv_step = step_idx + 3'd1;
                end
            end
            MODE_REV: begin
                if (step_idx == STEP_FIRST) begin
                    adv_step = STEP_LAST;
                    adv_wrap = 1'b1;
                end else begin
                    adv_step = step_idx - 3'd1;
                end
            end
            MODE_BOUNCE: begin
                // Endpoints are shown once; the pass ends on arrival back at 0.
                if (dir_up) begin
                    if (step_idx == STEP_LAST) begin
                        adv_step   = STEP_LAST - 3'd1;
                        adv_dir_up = 1'b0;
                    end else begin
                        adv_step = step_idx + 3'd1;
                    end
                end else begin
                    if (step_idx == STEP_FIRST) begin
                        adv_step   = STEP_FIRST + 3'd1;
                        adv_dir_up = 1'b1;
                    end else begin
                        adv_step = step_idx - 3'd1;
                        if (step_idx == STEP_FIRST + 3'd1) begin
                            adv_dir_up = 1'b1;
                            adv_wrap   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                // One-shot: wrap here means the final step has expired.
                if (step_idx == STEP_LAST) begin
                    adv_wrap = 1'b1;
                end else begin
                    adv_step = step_idx + 3'd1;
                end
            end
        endcase
    end

    // Timer is reloaded on entry and on every step advance, and only counts in RUN.
    always_comb begin
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        if (state == ST_IDLE) begin
            tmr_load = start && !stop;
        end else if (state == ST_RUN) begin
            tmr_en   = !stop && !pause;
            tmr_load = !stop && !pause && expired;
        end
    end

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (dwell),
        .enable   (tmr_en),
        .expired  (expired)
    );

    // Sequencer FSM with registered colour, step and status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_FWD;
            dir_up     <= 1'b1;
            step_idx   <= STEP_FIRST;
            r          <= '0;
            g          <= '0;
            b          <= '0;
            running    <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    {r, g, b} <= '0;
                    running   <= 1'b0;
                    if (start && !stop) begin
                        state     <= ST_RUN;
                        mode_q    <= mode;
                        dir_up    <= 1'b1;
                        step_idx  <= entry_step;
                        {r, g, b} <= hue_drive(entry_step, level);
                        running   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state     <= ST_IDLE;
                        step_idx  <= STEP_FIRST;
                        {r, g, b} <= '0;
                        running   <= 1'b0;
                    end else if (pause) begin
                        state <= ST_PAUSE;
                    end else if (!expired) begin
                        // Keep tracking level while the step is held.
                        {r, g, b} <= hue_drive(step_idx, level);
                    end else if ((mode_q == MODE_ONESHOT) && adv_wrap) begin
                        state      <= ST_IDLE;
                        step_idx   <= STEP_FIRST;
                        {r, g, b}  <= '0;
                        running    <= 1'b0;
                        cycle_done <= 1'b1;
                    end else begin
                        step_idx   <= adv_step;
                        dir_up     <= adv_dir_up;
                        {r, g, b}  <= hue_drive(adv_step, level);
                        cycle_done <= adv_wrap;
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        state     <= ST_IDLE;
                        step_idx  <= STEP_FIRST;
                        {r, g, b} <= '0;
                        running   <= 1'b0;
                    end else if (!pause) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    step_idx  <= STEP_FIRST;
                    {r, g, b} <= '0;
                    running   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crazy_light_seq.sv
// Bench for crazy_light_seq: a cycle model pushes expected outputs each edge,
// a negedge scoreboard pops and compares, plus directed checks per scenario.
// Inputs are driven on the falling edge.
module tb_crazy_light_seq;

    logic       clock;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic [1:0] mode;
    logic [7:0] dwell;
    logic [3:0] level;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic [2:0] step_idx;
    logic       running;
    logic       cycle_done;

    int checks = 0;
    int errors = 0;

    crazy_light_seq #(
        .COLOR_W (4),
        .DWELL_W (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .mode       (mode),
        .dwell      (dwell),
        .level      (level),
        .r          (r),
        .g          (g),
        .b          (b),
        .step_idx   (step_idx),
        .running    (running),
        .cycle_done (cycle_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic [2:0] step;
        logic       run;
        logic       done;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    int         m_state;
    int         m_pos;
    int         m_left;
    logic [1:0] m_mode;

    // Step shown at position p of the mode's visiting order.
    function automatic logic [2:0] seq_step(input logic [1:0] md, input int p);
        if (md == 2'd1) return 3'(5 - p);
        if (md == 2'd2) return (p <= 5) ? 3'(p) : 3'(10 - p);
        return 3'(p);
    endfunction

    function automatic int seq_len(input logic [1:0] md);
        return (md == 2'd2) ? 10 : 6;
    endfunction

    function automatic exp_t mk(input logic run, input logic [1:0] md, input int p,
                                input logic [3:0] lv, input logic done);
        exp_t       e;
        logic [2:0] s;
        e = '0;
        e.done = done;
        if (run) begin
            s      = seq_step(md, p);
            e.step = s;
            e.run  = 1'b1;
            e.r    = (s == 3'd0 || s == 3'd1 || s == 3'd5) ? lv : 4'h0;
            e.g    = (s == 3'd1 || s == 3'd2 || s == 3'd3) ? lv : 4'h0;
            e.b    = (s == 3'd3 || s == 3'd4 || s == 3'd5) ? lv : 4'h0;
        end
        return e;
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            m_state = 0;
            m_pos   = 0;
            m_left  = 0;
            m_mode  = 2'd0;
            cur     = '0;
        end else begin
            cur.done = 1'b0;
            case (m_state)
                0: if (start && !stop) begin
                    m_state = 1;
                    m_mode  = mode;
                    m_pos   = 0;
                    m_left  = int'(dwell);
                    cur     = mk(1'b1, m_mode, 0, level, 1'b0);
                end
                1: if (stop) begin
                    m_state = 0;
                    cur     = '0;
                end else if (pause) begin
                    m_state = 2;
                end else if (m_left > 0) begin
                    m_left--;
                    cur = mk(1'b1, m_mode, m_pos, level, 1'b0);
                end else if (m_mode == 2'd3 && m_pos == 5) begin
                    m_state = 0;
                    cur     = mk(1'b0, m_mode, 0, level, 1'b1);
                end else begin
                    m_pos  = (m_pos + 1) % seq_len(m_mode);
                    m_left = int'(dwell);
                    cur    = mk(1'b1, m_mode, m_pos, level, m_pos == 0);
                end
                default: if (stop) begin
                    m_state = 0;
                    cur     = '0;
                end else if (!pause) begin
                    m_state = 1;
                end
            endcase
        end
        q.push_back(cur);
    end

    // Scoreboard: compare DUT against the model on the falling edge.
    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("sb_rgb", 32'({r, g, b}), 32'({e.r, e.g, e.b}));
            check("sb_step", 32'(step_idx), 32'(e.step));
            check("sb_flags", 32'({running, cycle_done}), 32'({e.run, e.done}));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_step(input logic [2:0] s);
        int n;
        n = 0;
        while (step_idx !== s && n < 60) begin
            cyc(1);
            n++;
        end
        check("wait_step_timeout", 32'(step_idx), 32'(s));
    endtask

    task automatic go(input logic [1:0] md, input logic [7:0] dw, input logic [3:0] lv);
        mode  = md;
        dwell = dw;
        level = lv;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(1);
    endtask

    initial begin
        logic [2:0] bseq [12];
        int         cnt;
        bseq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};

        reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        mode  = 2'd0; dwell = 8'd0; level = 4'h0;
        cyc(2);
        check("rst_rgb", 32'({r, g, b}), 32'h0);
        check("rst_flags", 32'({running, cycle_done, step_idx}), 32'h0);
        reset = 1'b1;
        cyc(1);

        // Forward, dwell 2: three cycles per step, one pulse at 5->0.
        go(2'd0, 8'd2, 4'hF);
        check("fwd_first", 32'({r, g, b}), 32'h00000F00);
        cnt = 0;
        for (int i = 0; i < 18; i++) begin
            cyc(1);
            if (cycle_done) cnt++;
        end
        check("fwd_done_cnt", 32'(cnt), 32'd1);
        check("fwd_wrap_step", 32'(step_idx), 32'd0);
        cyc(3);
        check("fwd_loop_step", 32'(step_idx), 32'd1);
        halt();
        check("fwd_stop_run", 32'(running), 32'd0);

        // Bounce, dwell 0, level 7.
        go(2'd2, 8'd0, 4'h7);
        for (int i = 0; i < 12; i++) begin
            check("bnc_step", 32'(step_idx), 32'(bseq[i]));
            check("bnc_done", 32'(cycle_done), (i == 10) ? 32'd1 : 32'd0);
            if (i == 1) check("bnc_level", 32'({r, g, b}), 32'h00000770);
            cyc(1);
        end
        halt();

        // Pause mid-step, dwell 3.
        go(2'd0, 8'd3, 4'hF);
        cyc(2);
        pause = 1'b1;
        cyc(5);
        check("pause_step", 32'(step_idx), 32'd0);
        check("pause_run", 32'(running), 32'd1);
        check("pause_rgb", 32'({r, g, b}), 32'h00000F00);
        pause = 1'b0;
        cyc(2);
        check("resume_hold", 32'(step_idx), 32'd0);
        cyc(1);
        check("resume_adv", 32'(step_idx), 32'd1);
        halt();

        // Stop beats start in IDLE; stop while paused.
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        check("stop_prio", 32'(running), 32'd0);
        go(2'd0, 8'd3, 4'hF);
        pause = 1'b1;
        cyc(2);
        check("paused_run", 32'(running), 32'd1);
        stop = 1'b1;
        cyc(1);
        stop  = 1'b0;
        pause = 1'b0;
        check("pstop_flags", 32'({running, cycle_done}), 32'd0);
        check("pstop_rgb", 32'({r, g, b}), 32'h0);
        cyc(1);

        // One-shot, dwell 1: twelve active cycles; mode change mid-run ignored.
        go(2'd3, 8'd1, 4'hF);
        mode = 2'd0;
        for (int i = 0; i < 12; i++) begin
            check("os_running", 32'(running), 32'd1);
            cyc(1);
        end
        check("os_exit", 32'({running, cycle_done, step_idx}), 32'h00000008);
        check("os_rgb", 32'({r, g, b}), 32'h0);
        cyc(1);

        // Reverse, dwell 0: starts at step 5 (red+blue), wraps 0->5.
        go(2'd1, 8'd0, 4'hF);
        check("rev_first", 32'({r, g, b}), 32'h00000F0F);
        check("rev_step", 32'(step_idx), 32'd5);
        cyc(5);
        check("rev_low", 32'(step_idx), 32'd0);
        cyc(1);
        check("rev_wrap", 32'({step_idx, cycle_done}), 32'h0000000B);
        halt();

        // Maximum dwell: 256 cycles per step.
        go(2'd0, 8'hFF, 4'hF);
        cyc(255);
        check("dmax_hold", 32'(step_idx), 32'd0);
        cyc(1);
        check("dmax_adv", 32'(step_idx), 32'd1);
        halt();

        // Asynchronous reset during step 3.
        go(2'd0, 8'd2, 4'hF);
        wait_step(3'd3);
        @(posedge clock);
        #2;
        reset = 1'b0;
        q.delete();
        #1;
        check("arst_rgb", 32'({r, g, b}), 32'h0);
        check("arst_flags", 32'({running, cycle_done, step_idx}), 32'h0);
        cyc(2);
        reset = 1'b1;
        cyc(3);
        check("arst_idle", 32'({running, step_idx}), 32'h0);
        check("arst_idle_rgb", 32'({r, g, b}), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
